// File: rtl/pool_frame_sequencer.sv
// Round-robin sequencer that lends one 2x2/stride-2 pooling stage to NUM_CH channels,
// streaming the granted channel's frame in raster order and counting pooled results.
module pool_frame_sequencer #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 26,
  parameter int HEIGHT    = 26,
  parameter int DRAIN_CYC = 8,
  localparam int CH_W     = $clog2(NUM_CH),
  localparam int ADDR_W   = $clog2(WIDTH * HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_req,
  output logic [NUM_CH-1:0] ch_grant,
  output logic [NUM_CH-1:0] ch_done,
  output logic              rd_en,
  output logic [CH_W-1:0]   rd_ch,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output logic              pool_valid_in,
  output logic              pool_pixel_in,
  input  logic              pool_valid_out,
  output logic              busy,
  output logic              drain_err,
  output logic [1:0]        state_dbg
);

  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int OPF    = (WIDTH / 2) * (HEIGHT / 2);
  localparam int CNT_W  = $clog2(OPF + 1);
  localparam int DCNT_W = $clog2(DRAIN_CYC + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NPIX - 1);
  localparam logic [CNT_W-1:0]  OUT_FULL   = CNT_W'(OPF);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYC - 1);
  localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t              state, next_state;
  logic [CH_W-1:0]     rr_ptr, rr_ptr_d;
  logic [CNT_W-1:0]    out_cnt, out_cnt_d;
  logic [DCNT_W-1:0]   drain_cnt, drain_cnt_d;
  logic [NUM_CH-1:0]   grant_d, done_d;
  logic [CH_W-1:0]     rd_ch_d, pick_idx, cand;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic                rd_en_d, err_d, busy_d, pick_valid, drain_ok, drain_timeout;

  // Strobes carry no ready: rd_en and pool_valid_in are single-cycle valids that the
  // memory and the pooling stage must accept every cycle they are high.
  assign pool_pixel_in = pool_valid_in & rd_data;
  assign state_dbg     = state;
  assign drain_ok      = !pool_valid_in && (out_cnt == OUT_FULL);
  assign drain_timeout = (drain_cnt == DRAIN_LAST);

  // Lowest offset from rr_ptr+1 wins, so scan offsets from farthest to nearest.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (ch_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      rr_ptr        <= LAST_CH;
      out_cnt       <= '0;
      drain_cnt     <= '0;
      ch_grant      <= '0;
      ch_done       <= '0;
      rd_en         <= 1'b0;
      rd_ch         <= '0;
      rd_addr       <= '0;
      pool_valid_in <= 1'b0;
      busy          <= 1'b0;
      drain_err     <= 1'b0;
    end else begin
      state         <= next_state;
      rr_ptr        <= rr_ptr_d;
      out_cnt       <= out_cnt_d;
      drain_cnt     <= drain_cnt_d;
      ch_grant      <= grant_d;
      ch_done       <= done_d;
      rd_en         <= rd_en_d;
      rd_ch         <= rd_ch_d;
      rd_addr       <= rd_addr_d;
      pool_valid_in <= rd_en;
      busy          <= busy_d;
      drain_err     <= err_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (pick_valid) next_state = S_STREAM;
      S_STREAM: if (rd_addr == LAST_ADDR) next_state = S_DRAIN;
      S_DRAIN:  if (drain_ok || drain_timeout) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d     = ch_grant;
    done_d      = '0;
    rd_en_d     = 1'b0;
    rd_ch_d     = rd_ch;
    rd_addr_d   = rd_addr;
    out_cnt_d   = out_cnt;
    drain_cnt_d = drain_cnt;
    rr_ptr_d    = rr_ptr;
    err_d       = drain_err;
    busy_d      = (next_state != S_IDLE);
    // A result beyond the expected count means the pooling stage lost alignment.
    if ((state == S_STREAM || state == S_DRAIN) && pool_valid_out) begin
      if (out_cnt == OUT_FULL) err_d = 1'b1;
      else out_cnt_d = out_cnt + CNT_W'(1);
    end
    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d     = {{(NUM_CH-1){1'b0}}, 1'b1} << pick_idx;
          rd_ch_d     = pick_idx;
          rd_en_d     = 1'b1;
          rd_addr_d   = '0;
          out_cnt_d   = '0;
          drain_cnt_d = '0;
        end
      end
      S_STREAM: begin
        if (rd_addr == LAST_ADDR) begin
          rd_addr_d   = '0;
          drain_cnt_d = '0;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_ok) begin
          done_d = ch_grant;
        end else if (drain_timeout) begin
          done_d = ch_grant;
          err_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt + DCNT_W'(1);
        end
      end
      S_DONE: begin
        grant_d  = '0;
        rd_ch_d  = '0;
        rr_ptr_d = rd_ch;
      end
      default: ;
    endcase
  end

endmodule
